// File: rtl/dvi_pkg.sv
// Shared types and default 640x480@60 timing for the DVI timing controller.
package dvi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dvi_state_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // pix_data is packed {red, green, blue}
    localparam int unsigned CH_W      = 8;
    localparam int unsigned RGB_W     = 3 * CH_W;
    localparam int unsigned RED_LSB   = 2 * CH_W;
    localparam int unsigned GREEN_LSB = CH_W;
    localparam int unsigned BLUE_LSB  = 0;

endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// Pixel pull interface between the framebuffer reader (master) and the timing controller (slave).
interface dvi_timing_ctrl_if;
    import dvi_pkg::*;

    logic [RGB_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_rd;

    modport master (output pix_data, output pix_valid, input pix_rd);
    modport slave  (input pix_data, input pix_valid, output pix_rd);

endinterface

// File: rtl/dvi_timing_counter.sv
// Raster position counters with wrap, plus region decodes for active video and sync.
module dvi_timing_counter
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic active_c,
    output logic hs_c,
    output logic vs_c,
    output logic first_c,
    output logic last_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCNT_W  = $clog2(H_TOTAL);
    localparam int unsigned VCNT_W  = $clog2(V_TOTAL);

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic [31:0]       h_pos;
    logic [31:0]       v_pos;

    // Counters clear whenever the raster is not running; partial frames are abandoned
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign h_pos = 32'(hcnt);
    assign v_pos = 32'(vcnt);

    assign active_c = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign hs_c     = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
    assign vs_c     = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
    assign first_c  = (hcnt == '0) && (vcnt == '0);
    assign last_c   = (hcnt == H_LAST) && (vcnt == V_LAST);

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI video timing controller: frame-aligned start/stop, pixel pull and registered encoder outputs.
module dvi_timing_ctrl
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                pll_lckd,
    input  logic                enable,
    input  logic                underflow_clr,
    dvi_timing_ctrl_if.slave    pix,
    output logic [CH_W-1:0]     red_din,
    output logic [CH_W-1:0]     green_din,
    output logic [CH_W-1:0]     blue_din,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic                frame_start,
    output logic                underflow
);

    dvi_state_e       state;
    dvi_state_e       state_nxt;
    logic             run_c;
    logic             active_c;
    logic             hs_c;
    logic             vs_c;
    logic             first_c;
    logic             last_c;
    logic [RGB_W-1:0] rgb_q;

    // Losing lock takes effect in the same cycle, not just on the next state update
    assign run_c = (state != ST_IDLE) && pll_lckd;

    dvi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_counter (
        .clk      (clkin),
        .reset    (reset),
        .run      (run_c),
        .active_c (active_c),
        .hs_c     (hs_c),
        .vs_c     (vs_c),
        .first_c  (first_c),
        .last_c   (last_c)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stop request at the very last pixel goes straight to IDLE instead of draining a whole extra frame
    always_comb begin
        state_nxt = state;
        if (!pll_lckd) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (enable)  state_nxt = ST_RUN;
                ST_RUN:   if (!enable) state_nxt = last_c ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: if (last_c)  state_nxt = enable ? ST_RUN : ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    assign pix.pix_rd = active_c && run_c;

    // Encoder outputs trail the counter state by one clock
    always_ff @(posedge clkin) begin
        if (reset) begin
            de          <= 1'b0;
            rgb_q       <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            de          <= pix.pix_rd;
            rgb_q       <= (pix.pix_rd && pix.pix_valid) ? pix.pix_data : '0;
            hsync       <= (run_c && hs_c) ? HS_POL : ~HS_POL;
            vsync       <= (run_c && vs_c) ? VS_POL : ~VS_POL;
            frame_start <= (state == ST_RUN) && run_c && first_c;
            underflow   <= (pix.pix_rd && !pix.pix_valid) || (underflow && !underflow_clr);
        end
    end

    assign red_din   = rgb_q[RED_LSB   +: CH_W];
    assign green_din = rgb_q[GREEN_LSB +: CH_W];
    assign blue_din  = rgb_q[BLUE_LSB  +: CH_W];

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Randomized bench for dvi_timing_ctrl against a flat frame-position reference model.
module tb_dvi_timing_ctrl;
    import dvi_pkg::*;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam int NCYC = 6000;

    logic clkin = 1'b0;
    logic reset, pll_lckd, enable, underflow_clr;

    dvi_timing_ctrl_if pix_a ();
    dvi_timing_ctrl_if pix_b ();

    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic hsync_a, vsync_a, de_a, fs_a, uf_a;
    logic hsync_b, vsync_b, de_b, fs_b, uf_b;

    assign pix_b.pix_data  = pix_a.pix_data;
    assign pix_b.pix_valid = pix_a.pix_valid;

    dvi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clkin(clkin), .reset(reset), .pll_lckd(pll_lckd), .enable(enable),
        .underflow_clr(underflow_clr), .pix(pix_a),
        .red_din(red_a), .green_din(green_a), .blue_din(blue_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .frame_start(fs_a), .underflow(uf_a)
    );

    dvi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clkin(clkin), .reset(reset), .pll_lckd(pll_lckd), .enable(enable),
        .underflow_clr(underflow_clr), .pix(pix_b),
        .red_din(red_b), .green_din(green_b), .blue_din(blue_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .frame_start(fs_b), .underflow(uf_b)
    );

    always #5 clkin = ~clkin;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=drain, pos = linear pixel index within the frame
    int          mode;
    int unsigned pos;
    logic        e_de, e_hs, e_vs, e_hsb, e_vsb, e_fs, e_uf;
    logic [23:0] e_rgb;

    task automatic model_reset();
        mode = 0; pos = 0;
        e_de = 0; e_rgb = '0; e_fs = 0; e_uf = 0;
        e_hs = 1; e_vs = 1; e_hsb = 0; e_vsb = 0;
    endtask

    task automatic model_step();
        int unsigned col, line;
        logic running, act, hs_on, vs_on, last;
        col     = pos % HT;
        line    = pos / HT;
        running = (mode != 0) && pll_lckd;
        act     = running && (col < HA) && (line < VA);
        check("pix_rd_a", 32'(pix_a.pix_rd), 32'(act));
        check("pix_rd_b", 32'(pix_b.pix_rd), 32'(act));
        if (reset) begin
            model_reset();
        end else begin
            hs_on = running && (col >= HA + HF) && (col < HA + HF + HS);
            vs_on = running && (line >= VA + VF) && (line < VA + VF + VS);
            e_de  = act;
            e_rgb = (act && pix_a.pix_valid) ? pix_a.pix_data : 24'h0;
            e_hs  = !hs_on; e_vs = !vs_on;
            e_hsb = hs_on;  e_vsb = vs_on;
            e_fs  = running && (mode == 1) && (pos == 0);
            e_uf  = (act && !pix_a.pix_valid) || (e_uf && !underflow_clr);
            last  = (pos == FRAME - 1);
            if (!pll_lckd) begin
                mode = 0; pos = 0;
            end else if (mode == 0) begin
                if (enable) mode = 1;
            end else begin
                pos = last ? 0 : pos + 1;
                if (mode == 1 && !enable)
                    mode = last ? 0 : 2;
                else if (mode == 2 && last)
                    mode = enable ? 1 : 0;
            end
        end
    endtask

    initial begin
        int pll_hold;
        pll_hold = 0;
        reset = 1; pll_lckd = 0; enable = 0; underflow_clr = 0;
        pix_a.pix_data = '0; pix_a.pix_valid = 0;
        model_reset();
        repeat (2) @(posedge clkin);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clkin);
            #1;
            check("rgb_a", 32'({red_a, green_a, blue_a}), 32'(e_rgb));
            check("de_a", 32'(de_a), 32'(e_de));
            check("hsync_a", 32'(hsync_a), 32'(e_hs));
            check("vsync_a", 32'(vsync_a), 32'(e_vs));
            check("frame_start_a", 32'(fs_a), 32'(e_fs));
            check("underflow_a", 32'(uf_a), 32'(e_uf));
            check("hsync_b", 32'(hsync_b), 32'(e_hsb));
            check("vsync_b", 32'(vsync_b), 32'(e_vsb));
            check("de_b", 32'(de_b), 32'(e_de));

            reset = (cyc == 3000);
            if (pll_hold > 0) begin
                pll_hold--;
                pll_lckd = 0;
            end else if (cyc > 1200 && $urandom_range(0, 399) == 0) begin
                pll_hold = $urandom_range(0, 4);
                pll_lckd = 0;
            end else begin
                pll_lckd = 1;
            end
            if (cyc < 1200) enable = 1;
            else if ($urandom_range(0, 249) == 0) enable = !enable;
            pix_a.pix_valid = ($urandom_range(0, 11) != 0);
            pix_a.pix_data  = 24'($urandom);
            underflow_clr   = ($urandom_range(0, 31) == 0);
            #1;
            model_step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
